mdu_issue: RTL and testbench
============================

# mdu_issue

Issue/writeback sequencer that sits directly upstream of the multiplication & division unit. Accepts one M-extension request (op, two operands, destination tag) from the execute stage with valid/ready, presents it to the MDU as a single-cycle valid pulse with operands and op held stable, and captures the MDU result. It then offers the result to writeback with valid/ready and supports pipeline flush of an in-flight operation.

## Interface
- P_DATA_MSB, 31, operand/result MSB
- P_TAG_MSB, 4, destination-register tag MSB
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_flush  in  1  cancel current operation, no writeback
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid&ready
- i_req_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_req_rs1 / i_req_rs2  in  P_DATA_MSB+1  operands
- i_req_tag  in  P_TAG_MSB+1  destination tag
- o_mdu_rs1 / o_mdu_rs2  out  P_DATA_MSB+1  registered operands to MDU
- o_mdu_op  out  3  registered op to MDU
- o_mdu_valid  out  1  one-cycle issue pulse
- i_mdu_ready  in  1  MDU result strobe
- i_mdu_rd  in  P_DATA_MSB+1  MDU result, sampled when i_mdu_ready=1
- o_wb_valid  out  1  result valid
- i_wb_ready  in  1  writeback accepts
- o_wb_rd  out  P_DATA_MSB+1  result
- o_wb_tag  out  P_TAG_MSB+1  result tag

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- IDLE: o_req_ready=1; on accept, register op/rs1/rs2/tag onto o_mdu_* and tag reg -> ISSUE.
- ISSUE: o_mdu_valid=1 for exactly this cycle -> WAIT.
- WAIT: on i_mdu_ready, capture i_mdu_rd into o_wb_rd -> DONE.
- DONE: o_wb_valid=1; on i_wb_ready -> IDLE, or -> ISSUE if a new request is accepted in the same cycle.
- o_req_ready = (IDLE | (DONE & i_wb_ready)) & !i_flush.
- o_mdu_op/rs1/rs2 remain stable from ISSUE until the next accept; they never change while the MDU is busy.
- Flush: IDLE -> no accept; ISSUE -> IDLE, no o_mdu_valid pulse; WAIT -> DRAIN; DRAIN -> wait for i_mdu_ready, discard result, -> IDLE; DONE -> drop result, -> IDLE. Flush takes priority over accept and over wb handshake.
- i_mdu_ready outside WAIT/DRAIN is ignored.
- No result arithmetic in this block, except under the Configuration macro.
- Reset: state IDLE; o_mdu_valid=0, o_wb_valid=0, o_mdu_op/rs1/rs2=0, o_wb_rd=0, o_wb_tag=0; o_req_ready=1 after the reset cycle. Reset mid-operation abandons the operation; the MDU is reset on the same i_rst.

## Timing
- Accept at cycle N -> o_mdu_valid at N+1 -> result capture on the i_mdu_ready cycle -> o_wb_valid the next cycle.
- MUL family: MDU strobe at N+2, o_wb_valid at N+3.
- DIV/REM: WAIT has no timeout; the MDU strobe arrives about 34 cycles after the pulse.
- Back-to-back throughput: one op per 3 cycles for multiplication when i_wb_ready is held high.
- o_wb_valid/o_wb_rd/o_wb_tag hold stable until the handshake or a flush.

## Configuration
- MDU_DIV_FASTPATH_EN defined: in ISSUE, DIV/DIVU/REM/REMU with rs2==0 or signed overflow are resolved locally. No o_mdu_valid pulse is issued, and the block goes ISSUE -> DONE with o_wb_valid at N+2.
  - rs2==0: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - DIV, rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000; REM -> 0.
- Undefined: every op goes to the MDU; the result is whatever the MDU returns.

## Structure
- Shared package mdu_pkg: op encoding localparams (MDU_OP_MUL..MDU_OP_REMU) and state encoding.
- One sub-module, mdu_div_fastpath: combinational detect + result. Instantiated only under MDU_DIV_FASTPATH_EN.

## Test plan
- Reset, then MUL rs1=7, rs2=6, tag=3: exactly one o_mdu_valid pulse; o_mdu_op=000 held; MDU model strobes 42; o_wb_rd=42, o_wb_tag=3 at N+3.
- DIVU 100/7 with o_wb_valid held off by i_wb_ready=0 for 5 cycles: o_wb_rd=14 stable throughout; o_req_ready=0 until the handshake.
- DIV issued, i_flush in WAIT: the MDU strobe 30 cycles later is discarded; no o_wb_valid; o_req_ready returns the cycle after the strobe.
- Flush in the ISSUE cycle: no o_mdu_valid pulse; IDLE next cycle. Flush together with i_req_valid in IDLE: request not accepted.
- With MDU_DIV_FASTPATH_EN: DIVU x/0 -> 0xFFFFFFFF, REM 0x80000000/-1 -> 0, no MDU pulse, o_wb_valid at N+2. Without the macro: the same ops pulse the MDU.
- Two MULs back-to-back with i_wb_ready=1: second accepted in the first's DONE cycle; o_wb_valid at N+3 and N+6.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the MDU issue/writeback sequencer: op encodings,
// sequencer state encoding and a small op-class helper.
package mdu_pkg;

    localparam logic [2:0] MDU_OP_MUL    = 3'b000;
    localparam logic [2:0] MDU_OP_MULH   = 3'b001;
    localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
    localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
    localparam logic [2:0] MDU_OP_DIV    = 3'b100;
    localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
    localparam logic [2:0] MDU_OP_REM    = 3'b110;
    localparam logic [2:0] MDU_OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } mdu_state_e;

    // Division family occupies the upper half of the op space.
    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/mdu_div_fastpath.sv
// Combinational detection and result of trivially-resolvable divisions
// (divide by zero, signed overflow). Only built with MDU_DIV_FASTPATH_EN.
`ifdef MDU_DIV_FASTPATH_EN
module mdu_div_fastpath
    import mdu_pkg::*;
#(
    parameter int P_DATA_MSB = 31
) (
    input  logic [2:0]          i_op,
    input  logic [P_DATA_MSB:0] i_rs1,
    input  logic [P_DATA_MSB:0] i_rs2,
    output logic                o_hit,
    output logic [P_DATA_MSB:0] o_rd
);

    localparam logic [P_DATA_MSB:0] L_ONES = {(P_DATA_MSB+1){1'b1}};
    localparam logic [P_DATA_MSB:0] L_ZERO = {(P_DATA_MSB+1){1'b0}};
    localparam logic [P_DATA_MSB:0] L_MIN  = {1'b1, {P_DATA_MSB{1'b0}}};

    logic w_div;
    logic w_signed;
    logic w_is_rem;
    logic w_zero;
    logic w_ovf;

    assign w_div    = is_div_op(i_op);
    assign w_signed = ~i_op[0];
    assign w_is_rem = i_op[1];
    assign w_zero   = (i_rs2 == L_ZERO);
    assign w_ovf    = w_signed & (i_rs1 == L_MIN) & (i_rs2 == L_ONES);

    // Zero divisor takes precedence; overflow only applies to signed ops.
    always_comb begin
        o_hit = 1'b0;
        o_rd  = L_ZERO;
        if (w_div && w_zero) begin
            o_hit = 1'b1;
            o_rd  = w_is_rem ? i_rs1 : L_ONES;
        end else if (w_div && w_ovf) begin
            o_hit = 1'b1;
            o_rd  = w_is_rem ? L_ZERO : L_MIN;
        end else begin
            o_hit = 1'b0;
        end
    end

endmodule
`endif

// File: rtl/mdu_issue.sv
// Issue/writeback sequencer in front of the MDU. Optional local resolution of
// trivial divisions is enabled by defining MDU_DIV_FASTPATH_EN.
module mdu_issue
    import mdu_pkg::*;
#(
    parameter int P_DATA_MSB = 31,
    parameter int P_TAG_MSB  = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [2:0]          i_req_op,
    input  logic [P_DATA_MSB:0] i_req_rs1,
    input  logic [P_DATA_MSB:0] i_req_rs2,
    input  logic [P_TAG_MSB:0]  i_req_tag,
    output logic [P_DATA_MSB:0] o_mdu_rs1,
    output logic [P_DATA_MSB:0] o_mdu_rs2,
    output logic [2:0]          o_mdu_op,
    output logic                o_mdu_valid,
    input  logic                i_mdu_ready,
    input  logic [P_DATA_MSB:0] i_mdu_rd,
    output logic                o_wb_valid,
    input  logic                i_wb_ready,
    output logic [P_DATA_MSB:0] o_wb_rd,
    output logic [P_TAG_MSB:0]  o_wb_tag
);

    mdu_state_e          r_state;
    mdu_state_e          w_state_nxt;
    logic [2:0]          r_mdu_op;
    logic [P_DATA_MSB:0] r_mdu_rs1;
    logic [P_DATA_MSB:0] r_mdu_rs2;
    logic [P_TAG_MSB:0]  r_tag;
    logic [P_DATA_MSB:0] r_wb_rd;
    logic                w_accept;
    logic                w_fast_hit;

`ifdef MDU_DIV_FASTPATH_EN
    logic [P_DATA_MSB:0] w_fast_rd;

    mdu_div_fastpath #(.P_DATA_MSB(P_DATA_MSB)) u_fastpath (
        .i_op  (r_mdu_op),
        .i_rs1 (r_mdu_rs1),
        .i_rs2 (r_mdu_rs2),
        .o_hit (w_fast_hit),
        .o_rd  (w_fast_rd)
    );
`else
    assign w_fast_hit = 1'b0;
`endif

    assign o_req_ready = ((r_state == ST_IDLE) | ((r_state == ST_DONE) & i_wb_ready))
                         & ~i_flush & ~i_rst;
    assign w_accept    = i_req_valid & o_req_ready;
    assign o_mdu_valid = (r_state == ST_ISSUE) & ~i_flush & ~w_fast_hit;
    assign o_wb_valid  = (r_state == ST_DONE);
    assign o_mdu_op    = r_mdu_op;
    assign o_mdu_rs1   = r_mdu_rs1;
    assign o_mdu_rs2   = r_mdu_rs2;
    assign o_wb_rd     = r_wb_rd;
    assign o_wb_tag    = r_tag;

    // Next-state logic; flush outranks accept and the writeback handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_ISSUE;
                else          w_state_nxt = ST_IDLE;
            end
            ST_ISSUE: begin
                if (i_flush)         w_state_nxt = ST_IDLE;
                else if (w_fast_hit) w_state_nxt = ST_DONE;
                else                 w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A strobe coincident with flush completes the op: nothing left to drain.
                if (i_flush && i_mdu_ready) w_state_nxt = ST_IDLE;
                else if (i_flush)           w_state_nxt = ST_DRAIN;
                else if (i_mdu_ready)       w_state_nxt = ST_DONE;
                else                        w_state_nxt = ST_WAIT;
            end
            ST_DRAIN: begin
                if (i_mdu_ready) w_state_nxt = ST_IDLE;
                else             w_state_nxt = ST_DRAIN;
            end
            ST_DONE: begin
                if (i_flush)         w_state_nxt = ST_IDLE;
                else if (w_accept)   w_state_nxt = ST_ISSUE;
                else if (i_wb_ready) w_state_nxt = ST_IDLE;
                else                 w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Request capture and result capture; operands change only on accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mdu_op  <= 3'b000;
            r_mdu_rs1 <= {(P_DATA_MSB+1){1'b0}};
            r_mdu_rs2 <= {(P_DATA_MSB+1){1'b0}};
            r_tag     <= {(P_TAG_MSB+1){1'b0}};
            r_wb_rd   <= {(P_DATA_MSB+1){1'b0}};
        end else begin
            if (w_accept) begin
                r_mdu_op  <= i_req_op;
                r_mdu_rs1 <= i_req_rs1;
                r_mdu_rs2 <= i_req_rs2;
                r_tag     <= i_req_tag;
            end
            if ((r_state == ST_WAIT) && i_mdu_ready && !i_flush) begin
                r_wb_rd <= i_mdu_rd;
            end
`ifdef MDU_DIV_FASTPATH_EN
            if ((r_state == ST_ISSUE) && w_fast_hit && !i_flush) begin
                r_wb_rd <= w_fast_rd;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mdu_issue.sv
// Directed self-checking bench for mdu_issue; expectations follow
// MDU_DIV_FASTPATH_EN when it is defined for the build.
module tb_mdu_issue;

    logic        i_clk = 1'b0;
    logic        i_rst, i_flush, i_req_valid, i_mdu_ready, i_wb_ready;
    logic        o_req_ready, o_mdu_valid, o_wb_valid;
    logic [2:0]  i_req_op, o_mdu_op;
    logic [31:0] i_req_rs1, i_req_rs2, o_mdu_rs1, o_mdu_rs2, i_mdu_rd, o_wb_rd;
    logic [4:0]  i_req_tag, o_wb_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    int pulse_base;

    mdu_issue #(.P_DATA_MSB(31), .P_TAG_MSB(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_rs1(i_req_rs1), .i_req_rs2(i_req_rs2),
        .i_req_tag(i_req_tag), .o_mdu_rs1(o_mdu_rs1), .o_mdu_rs2(o_mdu_rs2),
        .o_mdu_op(o_mdu_op), .o_mdu_valid(o_mdu_valid), .i_mdu_ready(i_mdu_ready),
        .i_mdu_rd(i_mdu_rd), .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
        .o_wb_rd(o_wb_rd), .o_wb_tag(o_wb_tag)
    );

    always #5 i_clk = ~i_clk;

    // Count MDU issue pulses mid-cycle.
    always @(negedge i_clk) begin
        if (o_mdu_valid) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_rs1   = a;
        i_req_rs2   = b;
        i_req_tag   = tag;
    endtask

    initial begin
        i_rst = 1'b1; i_flush = 1'b0; i_req_valid = 1'b0; i_mdu_ready = 1'b0;
        i_wb_ready = 1'b0; i_req_op = 3'd0; i_req_rs1 = 32'd0; i_req_rs2 = 32'd0;
        i_req_tag = 5'd0; i_mdu_rd = 32'd0;
        step(); step();
        chk("rst_mdu_valid", 64'(o_mdu_valid), 64'd0);
        chk("rst_wb_valid", 64'(o_wb_valid), 64'd0);
        chk("rst_mdu_op", 64'(o_mdu_op), 64'd0);
        chk("rst_mdu_rs1", 64'(o_mdu_rs1), 64'd0);
        chk("rst_wb_rd", 64'(o_wb_rd), 64'd0);
        chk("rst_wb_tag", 64'(o_wb_tag), 64'd0);
        i_rst = 1'b0;
        #1 chk("rst_req_ready", 64'(o_req_ready), 64'd1);

        // MUL 7*6 tag 3
        pulse_base = pulse_cnt;
        req(3'b000, 32'd7, 32'd6, 5'd3);
        #1 chk("mul_accept", 64'(o_req_ready), 64'd1);
        step(); i_req_valid = 1'b0; #1;
        chk("mul_pulse", 64'(o_mdu_valid), 64'd1);
        chk("mul_op", 64'(o_mdu_op), 64'd0);
        chk("mul_rs1", 64'(o_mdu_rs1), 64'd7);
        chk("mul_rs2", 64'(o_mdu_rs2), 64'd6);
        step(); i_mdu_ready = 1'b1; i_mdu_rd = 32'd42; #1;
        chk("mul_pulse_off", 64'(o_mdu_valid), 64'd0);
        chk("mul_op_held", 64'(o_mdu_op), 64'd0);
        chk("mul_wait_nowb", 64'(o_wb_valid), 64'd0);
        step(); i_mdu_ready = 1'b0; i_wb_ready = 1'b1; #1;
        chk("mul_wb_valid", 64'(o_wb_valid), 64'd1);
        chk("mul_wb_rd", 64'(o_wb_rd), 64'd42);
        chk("mul_wb_tag", 64'(o_wb_tag), 64'd3);
        chk("mul_one_pulse", 64'(pulse_cnt - pulse_base), 64'd1);
        step(); i_wb_ready = 1'b0; #1;
        chk("mul_idle_wb", 64'(o_wb_valid), 64'd0);
        chk("mul_idle_ready", 64'(o_req_ready), 64'd1);

        // DIVU 100/7 with writeback stalled
        req(3'b101, 32'd100, 32'd7, 5'd9);
        step(); i_req_valid = 1'b0; #1;
        chk("divu_pulse", 64'(o_mdu_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            chk("divu_wait_ready", 64'(o_req_ready), 64'd0);
        end
        i_mdu_ready = 1'b1; i_mdu_rd = 32'd14;
        step(); i_mdu_ready = 1'b0; i_mdu_rd = 32'hDEAD_BEEF;
        req(3'b000, 32'd1, 32'd1, 5'd1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("divu_hold_valid", 64'(o_wb_valid), 64'd1);
            chk("divu_hold_rd", 64'(o_wb_rd), 64'd14);
            chk("divu_hold_tag", 64'(o_wb_tag), 64'd9);
            chk("divu_hold_ready", 64'(o_req_ready), 64'd0);
            chk("divu_hold_op", 64'(o_mdu_op), 64'd5);
            step();
        end
        i_req_valid = 1'b0; i_wb_ready = 1'b1;
        #1 chk("divu_hs_ready", 64'(o_req_ready), 64'd1);
        step(); i_wb_ready = 1'b0; #1;
        chk("divu_after_hs", 64'(o_wb_valid), 64'd0);

        // DIV flushed in WAIT; late strobe discarded
        req(3'b100, 32'd50, 32'd5, 5'd4);
        step(); i_req_valid = 1'b0;
        step(); i_flush = 1'b1; #1;
        chk("flushw_ready", 64'(o_req_ready), 64'd0);
        step(); i_flush = 1'b0;
        for (int i = 0; i < 29; i++) begin
            #1;
            chk("drain_ready", 64'(o_req_ready), 64'd0);
            step();
        end
        i_mdu_ready = 1'b1; i_mdu_rd = 32'd10; #1;
        chk("drain_strobe_ready", 64'(o_req_ready), 64'd0);
        step(); i_mdu_ready = 1'b0; #1;
        chk("drain_done_ready", 64'(o_req_ready), 64'd1);
        chk("drain_no_wb", 64'(o_wb_valid), 64'd0);
        chk("drain_rd_kept", 64'(o_wb_rd), 64'd14);

        // Flush in ISSUE, flush with request in IDLE, stray strobe in IDLE
        pulse_base = pulse_cnt;
        req(3'b000, 32'd2, 32'd3, 5'd5);
        step(); i_req_valid = 1'b0; i_flush = 1'b1; #1;
        chk("flushi_no_pulse", 64'(o_mdu_valid), 64'd0);
        step(); i_flush = 1'b0; #1;
        chk("flushi_idle", 64'(o_req_ready), 64'd1);
        chk("flushi_pulses", 64'(pulse_cnt - pulse_base), 64'd0);
        req(3'b000, 32'd2, 32'd3, 5'd5); i_flush = 1'b1; #1;
        chk("flush_idle_block", 64'(o_req_ready), 64'd0);
        step(); i_flush = 1'b0; i_req_valid = 1'b0; i_mdu_ready = 1'b1; i_mdu_rd = 32'hBAD; #1;
        chk("flush_idle_nopulse", 64'(o_mdu_valid), 64'd0);
        step(); i_mdu_ready = 1'b0; #1;
        chk("stray_no_wb", 64'(o_wb_valid), 64'd0);
        chk("stray_rd_kept", 64'(o_wb_rd), 64'd14);

        // DIVU x/0 and REM overflow
        pulse_base = pulse_cnt;
        req(3'b101, 32'd77, 32'd0, 5'd6);
        step(); i_req_valid = 1'b0; #1;
`ifdef MDU_DIV_FASTPATH_EN
        chk("fz_no_pulse", 64'(o_mdu_valid), 64'd0);
        step(); i_wb_ready = 1'b1; #1;
`else
        chk("fz_pulse", 64'(o_mdu_valid), 64'd1);
        step(); i_mdu_ready = 1'b1; i_mdu_rd = 32'hFFFF_FFFF;
        step(); i_mdu_ready = 1'b0; i_wb_ready = 1'b1; #1;
`endif
        chk("fz_wb_valid", 64'(o_wb_valid), 64'd1);
        chk("fz_wb_rd", 64'(o_wb_rd), 64'hFFFF_FFFF);
        step(); i_wb_ready = 1'b0;
        req(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
        step(); i_req_valid = 1'b0; #1;
`ifdef MDU_DIV_FASTPATH_EN
        chk("fo_no_pulse", 64'(o_mdu_valid), 64'd0);
        step(); i_wb_ready = 1'b1; #1;
        chk("fast_pulses", 64'(pulse_cnt - pulse_base), 64'd0);
`else
        chk("fo_pulse", 64'(o_mdu_valid), 64'd1);
        step(); i_mdu_ready = 1'b1; i_mdu_rd = 32'd0;
        step(); i_mdu_ready = 1'b0; i_wb_ready = 1'b1; #1;
        chk("slow_pulses", 64'(pulse_cnt - pulse_base), 64'd2);
`endif
        chk("fo_wb_valid", 64'(o_wb_valid), 64'd1);
        chk("fo_wb_rd", 64'(o_wb_rd), 64'd0);
        chk("fo_wb_tag", 64'(o_wb_tag), 64'd7);
        step(); i_wb_ready = 1'b0;

        // Back-to-back MULs with writeback always ready
        i_wb_ready = 1'b1;
        req(3'b000, 32'd3, 32'd5, 5'd1);
        step(); i_req_valid = 1'b0;
        step(); i_mdu_ready = 1'b1; i_mdu_rd = 32'd15;
        step(); i_mdu_ready = 1'b0; req(3'b000, 32'd4, 32'd4, 5'd2); #1;
        chk("b2b_wb1_valid", 64'(o_wb_valid), 64'd1);
        chk("b2b_wb1_rd", 64'(o_wb_rd), 64'd15);
        chk("b2b_wb1_tag", 64'(o_wb_tag), 64'd1);
        chk("b2b_accept2", 64'(o_req_ready), 64'd1);
        step(); i_req_valid = 1'b0; #1;
        chk("b2b_pulse2", 64'(o_mdu_valid), 64'd1);
        chk("b2b_rs1_2", 64'(o_mdu_rs1), 64'd4);
        chk("b2b_gap_wb", 64'(o_wb_valid), 64'd0);
        step(); i_mdu_ready = 1'b1; i_mdu_rd = 32'd16;
        step(); i_mdu_ready = 1'b0; #1;
        chk("b2b_wb2_valid", 64'(o_wb_valid), 64'd1);
        chk("b2b_wb2_rd", 64'(o_wb_rd), 64'd16);
        chk("b2b_wb2_tag", 64'(o_wb_tag), 64'd2);
        step(); i_wb_ready = 1'b0; #1;
        chk("b2b_end_idle", 64'(o_wb_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
